// File: rtl/parking_if.sv
// Bay sensor inputs and occupancy outputs between the pads, the monitor and the lot controller.
// The overstay vector exists only when PARKING_OVERSTAY_EN is defined.
interface parking_if #(
   parameter int NUM_SPACES = 8
) ();
   localparam int CNT_W = $clog2(NUM_SPACES + 1);

   logic [NUM_SPACES-1:0] sensors;
   logic [NUM_SPACES-1:0] space_occupied;
   logic [NUM_SPACES-1:0] arrive_pulse;
   logic [NUM_SPACES-1:0] depart_pulse;
   logic [CNT_W-1:0]      occupied_count;
   logic [CNT_W-1:0]      free_count;
   logic                  lot_full;
   logic                  lot_empty;
`ifdef PARKING_OVERSTAY_EN
   logic [NUM_SPACES-1:0] overstay;
`endif

   modport master (
      output sensors,
      input  space_occupied, arrive_pulse, depart_pulse,
      input  occupied_count, free_count, lot_full, lot_empty
`ifdef PARKING_OVERSTAY_EN
      , input overstay
`endif
   );

   modport slave (
      input  sensors,
      output space_occupied, arrive_pulse, depart_pulse,
      output occupied_count, free_count, lot_full, lot_empty
`ifdef PARKING_OVERSTAY_EN
      , output overstay
`endif
   );
endinterface

// File: rtl/parking_occupancy_monitor.sv
// Synchronises and debounces NUM_SPACES bay sensors into a registered occupancy map with event pulses,
// counts and full/empty flags. Define PARKING_OVERSTAY_EN to add per-bay overstay detection.
module parking_occupancy_monitor #(
   parameter int NUM_SPACES      = 8,
   parameter int DEBOUNCE_CYCLES = 4
`ifdef PARKING_OVERSTAY_EN
   , parameter int OVERSTAY_LIMIT = 1000
`endif
) (
   input  logic     clk,
   input  logic     rst,
   parking_if.slave bus
);
   localparam int CNT_W = $clog2(NUM_SPACES + 1);
   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

   logic [NUM_SPACES-1:0] s1, s2;
   logic [DB_W-1:0]       db_cnt [NUM_SPACES];
   logic [NUM_SPACES-1:0] occ, arrive, depart;
   logic [CNT_W-1:0]      occ_cnt, free_cnt;
   logic                  full, empty;

   logic [NUM_SPACES-1:0] accept, occ_next;
   logic [CNT_W-1:0]      cnt_next;

   // NOTE: every always_comb output gets a default before any conditional logic, so no latch is inferred.
   always_comb begin
      accept   = '0;
      cnt_next = '0;
      for (int i = 0; i < NUM_SPACES; i++) begin
         accept[i] = (s2[i] != occ[i]) && (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1));
      end
      occ_next = occ ^ accept;
      for (int i = 0; i < NUM_SPACES; i++) begin
         cnt_next = cnt_next + CNT_W'(occ_next[i]);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1       <= '0;
         s2       <= '0;
         occ      <= '0;
         arrive   <= '0;
         depart   <= '0;
         occ_cnt  <= '0;
         free_cnt <= CNT_W'(NUM_SPACES);
         full     <= 1'b0;
         empty    <= 1'b1;
         // NOTE: the per-bay counter array is ordinary flops, not RAM, so it is reset with everything else.
         for (int i = 0; i < NUM_SPACES; i++) db_cnt[i] <= '0;
      end else begin
         s1 <= bus.sensors;
         s2 <= s1;
         for (int i = 0; i < NUM_SPACES; i++) begin
            if (s2[i] == occ[i] || accept[i]) db_cnt[i] <= '0;
            else                              db_cnt[i] <= db_cnt[i] + 1'b1;
         end
         occ      <= occ_next;
         arrive   <= accept & occ_next;
         depart   <= accept & ~occ_next;
         occ_cnt  <= cnt_next;
         free_cnt <= CNT_W'(NUM_SPACES) - cnt_next;
         full     <= (cnt_next == CNT_W'(NUM_SPACES));
         empty    <= (cnt_next == '0);
      end
   end

   assign bus.space_occupied = occ;
   assign bus.arrive_pulse   = arrive;
   assign bus.depart_pulse   = depart;
   assign bus.occupied_count = occ_cnt;
   assign bus.free_count     = free_cnt;
   assign bus.lot_full       = full;
   assign bus.lot_empty      = empty;

`ifdef PARKING_OVERSTAY_EN
   localparam int OV_W = $clog2(OVERSTAY_LIMIT + 1);

   logic [OV_W-1:0]       ov_cnt  [NUM_SPACES];
   logic [OV_W-1:0]       ov_next [NUM_SPACES];
   logic [NUM_SPACES-1:0] ov_flag;

   // Counter restarts on arrival, saturates while parked and is cleared on departure.
   always_comb begin
      for (int i = 0; i < NUM_SPACES; i++) begin
         ov_next[i] = ov_cnt[i];
         if (!occ_next[i] || (accept[i] && occ_next[i])) ov_next[i] = '0;
         else if (occ[i] && ov_cnt[i] < OV_W'(OVERSTAY_LIMIT)) ov_next[i] = ov_cnt[i] + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ov_flag <= '0;
         for (int i = 0; i < NUM_SPACES; i++) ov_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_SPACES; i++) begin
            ov_cnt[i]  <= ov_next[i];
            ov_flag[i] <= (ov_next[i] == OV_W'(OVERSTAY_LIMIT)) && occ_next[i];
         end
      end
   end

   assign bus.overstay = ov_flag;
`endif
endmodule

// File: tb/tb_parking_occupancy_monitor.sv
// Randomised and directed bench for parking_occupancy_monitor against a sample-window model of the bays.
// Build with PARKING_OVERSTAY_EN defined to also exercise overstay detection.
module tb_parking_occupancy_monitor;
   localparam int N   = 8;
   localparam int D   = 4;
   localparam int LIM = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   parking_if #(.NUM_SPACES(N)) bus ();

   parking_occupancy_monitor #(
      .NUM_SPACES(N),
      .DEBOUNCE_CYCLES(D)
`ifdef PARKING_OVERSTAY_EN
      , .OVERSTAY_LIMIT(LIM)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a bay flips once the last D synchronised samples all disagree with its current state.
   // hist[j] holds the raw sensor word sampled j+1 edges ago; the synchroniser output seen at an
   // edge is therefore hist[1], and the debounce window is hist[1..D].
   logic [N-1:0] hist [D+1];
   logic [N-1:0] m_occ, m_arr, m_dep, m_ov;
   int           dur [N];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j <= D; j++) hist[j] = '0;
         m_occ = '0; m_arr = '0; m_dep = '0; m_ov = '0;
         for (int i = 0; i < N; i++) dur[i] = 0;
      end else begin
         logic [N-1:0] flip;
         flip = '0;
         for (int i = 0; i < N; i++) begin
            bit all_differ;
            all_differ = 1'b1;
            for (int j = 1; j <= D; j++) if (hist[j][i] == m_occ[i]) all_differ = 1'b0;
            flip[i] = all_differ;
         end
         m_arr = flip & ~m_occ;
         m_dep = flip & m_occ;
         m_occ = m_occ ^ flip;
         for (int i = 0; i < N; i++) begin
            if (!m_occ[i] || m_arr[i]) dur[i] = 0;
            else                       dur[i] = dur[i] + 1;
            m_ov[i] = m_occ[i] && (dur[i] >= LIM);
         end
         for (int j = D; j >= 1; j--) hist[j] = hist[j-1];
         hist[0] = bus.sensors;
      end
   end

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      int c;
      c = $countones(m_occ);
      check("occupied", 32'(bus.space_occupied), 32'(m_occ));
      check("arrive", 32'(bus.arrive_pulse), 32'(m_arr));
      check("depart", 32'(bus.depart_pulse), 32'(m_dep));
      check("occ_count", 32'(bus.occupied_count), 32'(c));
      check("free_count", 32'(bus.free_count), 32'(N - c));
      check("lot_full", 32'(bus.lot_full), 32'(c == N));
      check("lot_empty", 32'(bus.lot_empty), 32'(c == 0));
`ifdef PARKING_OVERSTAY_EN
      check("overstay", 32'(bus.overstay), 32'(m_ov));
`endif
   end

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      bus.sensors = '0;
      wait_neg(3);
      rst = 1'b0;
      wait_neg(2);

      // Reset state
      check("rst_occ", 32'(bus.space_occupied), 32'h0);
      check("rst_count", 32'(bus.occupied_count), 32'd0);
      check("rst_free", 32'(bus.free_count), 32'd8);
      check("rst_empty", 32'(bus.lot_empty), 32'd1);
      check("rst_full", 32'(bus.lot_full), 32'd0);

      // Single arrival: visible on the 5th edge after the s1 capture
      bus.sensors = 8'h08;
      wait_neg(5);
      check("lat_early", 32'(bus.space_occupied), 32'h00);
      wait_neg(1);
      check("lat_occ", 32'(bus.space_occupied), 32'h08);
      check("lat_arrive", 32'(bus.arrive_pulse), 32'h08);
      check("lat_count", 32'(bus.occupied_count), 32'd1);
      wait_neg(1);
      check("arrive_1cyc", 32'(bus.arrive_pulse), 32'h00);

      // Three-cycle glitch on bay 5 is ignored
      bus.sensors = 8'h28;
      wait_neg(3);
      bus.sensors = 8'h08;
      wait_neg(10);
      check("glitch_occ", 32'(bus.space_occupied), 32'h08);
      check("glitch_count", 32'(bus.occupied_count), 32'd1);

      // All bays together, then bay 0 leaves
      bus.sensors = 8'h00;
      wait_neg(10);
      bus.sensors = 8'hFF;
      wait_neg(6);
      check("all_arrive", 32'(bus.arrive_pulse), 32'hFF);
      check("all_count", 32'(bus.occupied_count), 32'd8);
      check("all_full", 32'(bus.lot_full), 32'd1);
      check("all_free", 32'(bus.free_count), 32'd0);
      bus.sensors = 8'hFE;
      wait_neg(6);
      check("drop_depart", 32'(bus.depart_pulse), 32'h01);
      check("drop_count", 32'(bus.occupied_count), 32'd7);
      check("drop_full", 32'(bus.lot_full), 32'd0);

      // Reset mid-operation with five cars present
      bus.sensors = 8'h1F;
      wait_neg(10);
      check("pre_rst_count", 32'(bus.occupied_count), 32'd5);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_occ", 32'(bus.space_occupied), 32'h00);
      check("mid_rst_count", 32'(bus.occupied_count), 32'd0);
      check("mid_rst_free", 32'(bus.free_count), 32'd8);
      check("mid_rst_empty", 32'(bus.lot_empty), 32'd1);
      wait_neg(2);
      rst = 1'b0;
      wait_neg(5);
      check("rearr_early", 32'(bus.occupied_count), 32'd0);
      wait_neg(1);
      check("rearr_arrive", 32'(bus.arrive_pulse), 32'h1F);
      check("rearr_count", 32'(bus.occupied_count), 32'd5);

`ifdef PARKING_OVERSTAY_EN
      // Bay 2 parks for LIM cycles, then leaves
      bus.sensors = 8'h00;
      wait_neg(10);
      bus.sensors = 8'h04;
      wait_neg(6);
      check("ov_arrive", 32'(bus.arrive_pulse), 32'h04);
      wait_neg(LIM - 1);
      check("ov_early", 32'(bus.overstay), 32'h00);
      wait_neg(1);
      check("ov_set", 32'(bus.overstay), 32'h04);
      wait_neg(5);
      check("ov_hold", 32'(bus.overstay), 32'h04);
      bus.sensors = 8'h00;
      wait_neg(6);
      check("ov_depart", 32'(bus.depart_pulse), 32'h04);
      check("ov_clear", 32'(bus.overstay), 32'h00);
`endif

      // Random traffic: each bay toggles with ~1/6 chance per cycle, giving both glitches and stable runs
      for (int k = 0; k < 3000; k++) begin
         logic [N-1:0] mask;
         for (int i = 0; i < N; i++) mask[i] = ($urandom_range(0, 5) == 0);
         if (k % 50 >= 30) mask = '0;
         bus.sensors = bus.sensors ^ mask;
         if (k == 1500) begin
            #2 rst = 1'b1;
            wait_neg(2);
            rst = 1'b0;
         end else begin
            wait_neg(1);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
